// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: controller states and queue entry layout.
package fetch_pkg;

  localparam int FETCH_QDEPTH = 2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order buffer between fetch and decode; head visible the cycle after enqueue.
// Flush wins over enqueue/dequeue; the producer never enqueues into a full queue.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  fetch_entry_t enq_dat,
  input  logic         deq,
  input  logic         flush,
  output logic         head_vld,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  assign head_vld = (count != 2'd0);
  assign head_dat = slot0;

  // slot0 is always the head; slot1 only holds data when count==2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) slot0 <= enq_dat;
          else               slot1 <= enq_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= enq_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= enq_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the single-outstanding imem handshake, feeds decode through
// a 2-entry queue (ack to if_valid in 1 cycle); stops requesting while the queue is full.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] HALT_INST = 32'h0000_0000,
  parameter bit          HALT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_pc,
  output logic        halt,
  output logic        err,
  output logic [31:0] if_count
);

  fetch_state_e state;
  logic [31:0]  target;
  logic [1:0]   occ;
  fetch_entry_t head;
  fetch_entry_t enq_dat;

  logic acc, consume, active, redir, bad_redir, mem_fault, is_halt, flush, enq;

  // In DRAIN fetch_pc still holds the address of the abandoned request, so addr stays put.
  assign imem_req  = !rst && ((state == FETCH && occ < 2'd2) || state == DRAIN);
  assign imem_addr = fetch_pc;

  assign acc       = imem_req && imem_ack;
  assign consume   = if_valid && !stall_d;
  assign active    = (state == FETCH) || (state == DRAIN);
  assign redir     = active && redirect_valid;
  assign bad_redir = redir && (redirect_pc[1:0] != 2'b00);
  assign mem_fault = acc && imem_err;
  assign is_halt   = HALT_EN && (imem_rdata == HALT_INST);
  assign flush     = mem_fault || redir;
  assign enq       = acc && !imem_err && !redir && (state == FETCH) && !is_halt;
  assign enq_dat   = '{pc: fetch_pc, inst: imem_rdata};

  fetch_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq),
    .enq_dat  (enq_dat),
    .deq      (consume && !flush),
    .flush    (flush),
    .head_vld (if_valid),
    .head_dat (head),
    .count    (occ)
  );

  assign if_pc   = head.pc;
  assign if_inst = head.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      target   <= '0;
      halt     <= 1'b0;
      err      <= 1'b0;
      if_count <= '0;
    end else begin
      if (consume) if_count <= if_count + 32'd1;
      case (state)
        FETCH, DRAIN: begin
          if (mem_fault) begin
            state <= ERROR;
            err   <= 1'b1;
          end else if (redir) begin
            if (bad_redir) begin
              state <= ERROR;
              err   <= 1'b1;
            end else if (!imem_req || acc) begin
              fetch_pc <= redirect_pc;
              state    <= FETCH;
            end else begin
              // Request still in flight: wait for its ack before moving the PC.
              target <= redirect_pc;
              state  <= DRAIN;
            end
          end else if (acc) begin
            if (state == DRAIN) begin
              fetch_pc <= target;
              state    <= FETCH;
            end else if (is_halt) begin
              state <= HALTED;
              halt  <= 1'b1;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: single-edge vector table, directed multi-cycle sequences, and a
// randomized run checked against an in-order instruction-stream model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_d = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] fetch_pc;
  logic        halt;
  logic        err;
  logic [31:0] if_count;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .fetch_pc       (fetch_pc),
    .halt           (halt),
    .err            (err),
    .if_count       (if_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          lat = 0;
  int          wc = 0;
  int          ack_no = 0;
  int          err_at = -1;
  bit          rand_lat = 1'b0;
  bit          use_prog = 1'b0;
  logic [31:0] prog [8];
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] idx;
    idx = ((a - 32'h1000) >> 2) & 32'h7;
    if (use_prog) return prog[idx[2:0]];
    return {a[15:0] ^ 16'h5a5a, a[15:0]} | 32'h1;
  endfunction

  task automatic drive_mem();
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    if (prev_wait) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, prev_addr);
    end
    prev_wait = 1'b0;
    if (imem_req) begin
      if (wc >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        imem_err   = (ack_no == err_at);
        ack_no++;
        wc = 0;
        if (rand_lat) lat = int'($urandom_range(0, 3));
      end else begin
        wc++;
        prev_wait = 1'b1;
        prev_addr = imem_addr;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    redirect_valid = 1'b0;
    drive_mem();
  endtask

  typedef struct {
    bit          is_redir;
    logic [31:0] pc;
    logic [31:0] inst;
  } ev_t;
  ev_t evq[$];
  int  max_occ = 0;

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    redirect_valid = 1'b0;
    stall_d = 1'b0;
    wc = 0;
    ack_no = 0;
    prev_wait = 1'b0;
    repeat (2) @(negedge clk);
    evq.delete();
    rst = 1'b0;
  endtask

  // Log decode consumptions and accepted redirects in edge order.
  always @(posedge clk) begin
    if (!rst) begin
      if (if_valid && !stall_d) evq.push_back('{1'b0, if_pc, if_inst});
      if (redirect_valid && !halt && !err) evq.push_back('{1'b1, redirect_pc, 32'h0});
      if (int'(dut.u_queue.count) > max_occ) max_occ = int'(dut.u_queue.count);
    end
  end

  // Reference: decode sees consecutive PCs from the start address, restarting at each redirect.
  task automatic check_stream(input logic [31:0] start, output int n);
    logic [31:0] exp_pc;
    exp_pc = start;
    n = 0;
    foreach (evq[i]) begin
      if (evq[i].is_redir) begin
        exp_pc = evq[i].pc;
      end else begin
        check("stream_pc", evq[i].pc, exp_pc);
        check("stream_inst", evq[i].inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n++;
      end
    end
  endtask

  typedef struct {
    bit          ack;
    logic [31:0] rdata;
    bit          ierr;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] efpc;
    bit          ereq;
    bit          ehalt;
    bit          eerr;
  } vec_t;
  vec_t vt[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    vt[0] = '{1'b1, 32'h13, 1'b0, 1'b0, 32'h0,    1'b1, 32'h1000, 32'h1004, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 32'h13, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 32'h13, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,    32'h2000, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h2002, 1'b0, 32'h0,    32'h1000, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h1000, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 32'h0,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1000, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 32'h0,  1'b0, 1'b1, 32'h2000, 1'b0, 32'h0,    32'h2000, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h1000, 1'b1, 1'b0, 1'b0};

    // Single-edge vectors applied from the reset state.
    for (int i = 0; i < 9; i++) begin
      reset_dut();
      stall_d        = 1'b1;
      imem_ack       = vt[i].ack;
      imem_rdata     = vt[i].rdata;
      imem_err       = vt[i].ierr;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      @(negedge clk);
      imem_ack       = 1'b0;
      imem_err       = 1'b0;
      redirect_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vt[i].ev));
      if (vt[i].ev) check($sformatf("vec%0d_pc", i), if_pc, vt[i].epc);
      check($sformatf("vec%0d_fetch_pc", i), fetch_pc, vt[i].efpc);
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].ereq));
      check($sformatf("vec%0d_halt", i), 32'(halt), 32'(vt[i].ehalt));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].eerr));
    end

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    reset_dut();
    lat = 0;
    repeat (4) step();
    #2;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    prev_wait = 1'b0;
    wc = 0;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_halt", 32'(halt), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_count", if_count, 32'd0);
    check("arst_fetch_pc", fetch_pc, 32'h1000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h1000);

    // Zero-wait memory: 0x1,0x2,0x3 then halt word.
    use_prog = 1'b1;
    prog[0] = 32'h1; prog[1] = 32'h2; prog[2] = 32'h3; prog[3] = 32'h0;
    prog[4] = 32'h9; prog[5] = 32'h9; prog[6] = 32'h9; prog[7] = 32'h9;
    reset_dut();
    lat = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("zw_valid", 32'(if_valid), 32'd1);
      check("zw_pc", if_pc, 32'h1000 + 32'(k * 4));
      check("zw_inst", if_inst, 32'(k + 1));
    end
    step();
    check("zw_count", if_count, 32'd3);
    check("halt_set", 32'(halt), 32'd1);
    check("halt_valid", 32'(if_valid), 32'd0);
    check("halt_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    step();
    step();
    check("halt_redir_ign", fetch_pc, 32'h100c);
    check("halt_redir_req", 32'(imem_req), 32'd0);
    check("halt_sticky", 32'(halt), 32'd1);
    use_prog = 1'b0;

    // Decode stall fills the queue and throttles requests.
    reset_dut();
    lat = 0;
    stall_d = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 2) begin
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_pc", if_pc, 32'h1000);
        check("stall_inst", if_inst, memf(32'h1000));
      end
    end
    stall_d = 1'b0;
    repeat (8) step();
    check_stream(32'h1000, n);
    check("stall_count", if_count, 32'(n));
    check("stall_progress", 32'(n >= 6), 32'd1);

    // Redirect while a slow request is outstanding.
    reset_dut();
    lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    step();
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_addr", imem_addr, 32'h1000);
    step();
    step();
    step();
    check("drain_newaddr", imem_addr, 32'h2000);
    check("drain_newreq", 32'(imem_req), 32'd1);
    check("drain_discard", 32'(if_valid), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    check("drain_found", 32'(found), 32'd1);
    check("drain_first_pc", if_pc, 32'h2000);

    // Memory error on the second ack.
    reset_dut();
    lat = 0;
    err_at = 1;
    step();
    step();
    step();
    check("merr_err", 32'(err), 32'd1);
    check("merr_valid", 32'(if_valid), 32'd0);
    check("merr_req", 32'(imem_req), 32'd0);
    err_at = -1;

    // Randomized traffic against the stream model.
    reset_dut();
    rand_lat = 1'b1;
    lat = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      stall_d = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000 + ($urandom_range(0, 255) << 2);
      end
    end
    step();
    check_stream(32'h1000, n);
    check("rand_count", if_count, 32'(n));
    check("rand_progress", 32'(n > 300), 32'd1);
    check("rand_no_err", 32'(err | halt), 32'd0);
    check("max_occupancy", 32'(max_occ <= 2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
